mario_vram_arbiter: RTL

MARIO_VRAM_ARBITER -- requirements
Module: mario_vram_arbiter

---
 rtl/mario_vram_pkg.sv | 14 +
 rtl/mario_vram_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mario_vram_pkg.sv
// Shared types and constants for the Mario VRAM arbiter.
package mario_vram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CPU  = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam logic [2:0] SLOT_MATCH = 3'b111;
  localparam int unsigned CNT_W     = 2;

endpackage

// File: rtl/mario_vram_arbiter.sv
// VRAM arbiter: video tile fetches (priority, 1-deep pending) and CPU read/write access.
// Optional MARIO_VRAM_CPU_BLANK_ONLY_EN restricts CPU grants to the blanking interval.
module mario_vram_arbiter
  import mario_vram_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_PIX_CE,
  input  logic [9:0]        I_H_CNT,
  input  logic              I_C_BLANKn,
  input  logic [ADDR_W-1:0] I_VID_ADDR,
  output logic [DATA_W-1:0] O_VID_DATA,
  output logic              O_VID_VALID,
  output logic              O_VID_MISS,
  input  logic              I_CPU_REQ,
  input  logic              I_CPU_WE,
  input  logic [ADDR_W-1:0] I_CPU_ADDR,
  input  logic [DATA_W-1:0] I_CPU_WDATA,
  output logic [DATA_W-1:0] O_CPU_RDATA,
  output logic              O_CPU_ACK,
  output logic              O_CPU_WAIT,
  output logic [ADDR_W-1:0] O_RAM_ADDR,
  output logic              O_RAM_WE,
  output logic [DATA_W-1:0] O_RAM_WDATA,
  input  logic [DATA_W-1:0] I_RAM_RDATA
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              seen_low_q, seen_low_d;
  logic              cpu_we_q, cpu_we_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              vid_valid_q, vid_valid_d;
  logic              vid_miss_q, vid_miss_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic slot_c;
  logic cpu_new_c;
  logic cpu_ok_c;
  logic lat_done_c;
  logic unused_h_cnt_c;

  assign slot_c         = I_PIX_CE & (I_H_CNT[2:0] == SLOT_MATCH) & I_C_BLANKn;
  assign cpu_new_c      = I_CPU_REQ & seen_low_q;
  assign lat_done_c     = (cnt_q == CNT_W'(RAM_LAT - 1));
  assign unused_h_cnt_c = ^I_H_CNT[9:3];

`ifdef MARIO_VRAM_CPU_BLANK_ONLY_EN
  assign cpu_ok_c = ~I_C_BLANKn;
`else
  assign cpu_ok_c = 1'b1;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    seen_low_d  = seen_low_q;
    cpu_we_d    = cpu_we_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    vid_miss_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;

    if (!I_CPU_REQ) begin
      seen_low_d = 1'b1;
    end

    // A slot that cannot be served now is queued; a second one drops the first
    if (slot_c && (state_q != ST_IDLE)) begin
      pend_d      = 1'b1;
      pend_addr_d = I_VID_ADDR;
      vid_miss_d  = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (slot_c || pend_q) begin
          state_d    = ST_VID;
          cnt_d      = '0;
          ram_addr_d = slot_c ? I_VID_ADDR : pend_addr_q;
          pend_d     = 1'b0;
          vid_miss_d = slot_c & pend_q;
        end else if (cpu_new_c && cpu_ok_c) begin
          state_d     = ST_CPU;
          cnt_d       = '0;
          ram_addr_d  = I_CPU_ADDR;
          ram_wdata_d = I_CPU_WDATA;
          ram_we_d    = I_CPU_WE;
          cpu_we_d    = I_CPU_WE;
          seen_low_d  = 1'b0;
        end
      end
      ST_VID: begin
        if (lat_done_c) begin
          state_d     = ST_IDLE;
          vid_data_d  = I_RAM_RDATA;
          vid_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CPU: begin
        if (lat_done_c) begin
          state_d   = ST_ACK;
          cpu_ack_d = 1'b1;
          if (!cpu_we_q) begin
            cpu_rdata_d = I_RAM_RDATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      seen_low_q  <= 1'b1;
      cpu_we_q    <= 1'b0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      vid_miss_q  <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      seen_low_q  <= seen_low_d;
      cpu_we_q    <= cpu_we_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      vid_miss_q  <= vid_miss_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign O_VID_DATA  = vid_data_q;
  assign O_VID_VALID = vid_valid_q;
  assign O_VID_MISS  = vid_miss_q;
  assign O_CPU_RDATA = cpu_rdata_q;
  assign O_CPU_ACK   = cpu_ack_q;
  assign O_CPU_WAIT  = I_CPU_REQ & ~cpu_ack_q;
  assign O_RAM_ADDR  = ram_addr_q;
  assign O_RAM_WE    = ram_we_q;
  assign O_RAM_WDATA = ram_wdata_q;

endmodule
